// File: rtl/tea_pkg.sv
// Shared definitions for the TEA io mailbox: FSM encoding, io address map, status bits.
// The key window (KEY_BASE..KEY_BASE+15) is only populated when TEA_MBOX_KEY_EN is defined.
package tea_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int          IO_AW           = 5;
   localparam logic [4:0]  ADDR_DATA_BASE  = 5'h00;
   localparam logic [4:0]  ADDR_KEY_BASE   = 5'h08;
   localparam logic [4:0]  ADDR_TRACE      = 5'h1E;
   localparam logic [4:0]  ADDR_STATUS     = 5'h1F;
   localparam int          DATA_BYTES      = 8;
   localparam int          KEY_BYTES       = 16;

   // Status register bit positions
   localparam int          STAT_IDLE_N_BIT = 0;
   localparam int          STAT_OUT_VLD_BIT = 1;

endpackage

// File: rtl/tea_io_mailbox_if.sv
// Host/downstream block handshakes plus the CPU io port of the TEA mailbox.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
// valid and its data must not change or drop while ready is low.
interface tea_io_mailbox_if #(
   parameter int IO_ADDR_WIDTH = 5
);
   logic                     in_valid;
   logic                     in_ready;
   logic [63:0]              in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [63:0]              out_data;
   logic [IO_ADDR_WIDTH-1:0] io_addr;
   logic                     io_rd;
   logic                     io_wr;
   logic [7:0]               io_wrdata;
   logic [7:0]               io_rddata;
   logic [7:0]               round_cnt;

   modport slave (
      input  in_valid, in_data, out_ready, io_addr, io_rd, io_wr, io_wrdata,
      output in_ready, out_valid, out_data, io_rddata, round_cnt
   );

   modport master (
      output in_valid, in_data, out_ready, io_addr, io_rd, io_wr, io_wrdata,
      input  in_ready, out_valid, out_data, io_rddata, round_cnt
   );
endinterface

// File: rtl/tea_io_regmap.sv
// Combinational io read mux and write decode for the TEA mailbox.
// With TEA_MBOX_KEY_EN the key buffer is readable at KEY_BASE..KEY_BASE+15.
module tea_io_regmap
   import tea_pkg::*;
#(
   parameter int                       IO_ADDR_WIDTH = IO_AW,
   parameter logic [IO_ADDR_WIDTH-1:0] STATUS_ADDR   = IO_ADDR_WIDTH'(ADDR_STATUS),
   parameter logic [IO_ADDR_WIDTH-1:0] TRACE_ADDR    = IO_ADDR_WIDTH'(ADDR_TRACE),
   parameter logic [IO_ADDR_WIDTH-1:0] KEY_BASE      = IO_ADDR_WIDTH'(ADDR_KEY_BASE)
) (
   input  logic [IO_ADDR_WIDTH-1:0] addr_i,
   input  logic                     wr_i,
   input  state_e                   state_i,
   input  logic                     out_valid_i,
   input  logic [63:0]              in_buf_i,
   input  logic [7:0]               round_cnt_i,
`ifdef TEA_MBOX_KEY_EN
   input  logic [127:0]             key_buf_i,
`endif
   output logic [7:0]               rddata_o,
   output logic [7:0]               res_we_o,
   output logic                     trace_inc_o,
   output logic                     status_wr_o
);

   logic is_data;
   assign is_data = (addr_i < IO_ADDR_WIDTH'(DATA_BYTES));

`ifdef TEA_MBOX_KEY_EN
   logic       is_key;
   logic [3:0] key_idx;
   assign is_key  = (int'(addr_i) >= int'(KEY_BASE)) &&
                    (int'(addr_i) <  int'(KEY_BASE) + KEY_BYTES);
   assign key_idx = 4'(addr_i - KEY_BASE);
`endif

   always_comb begin
      rddata_o = '0;
      if (is_data) begin
         rddata_o = in_buf_i[8*addr_i[2:0] +: 8];
      end else if (addr_i == TRACE_ADDR) begin
         rddata_o = round_cnt_i;
      end else if (addr_i == STATUS_ADDR) begin
         rddata_o[STAT_IDLE_N_BIT]  = (state_i != ST_PEND);
         rddata_o[STAT_OUT_VLD_BIT] = out_valid_i;
`ifdef TEA_MBOX_KEY_EN
      end else if (is_key) begin
         rddata_o = key_buf_i[8*key_idx +: 8];
`endif
      end
   end

   // All writes are meaningful only while the CPU owns a pending request
   always_comb begin
      res_we_o    = '0;
      trace_inc_o = 1'b0;
      status_wr_o = 1'b0;
      if (wr_i && state_i == ST_PEND) begin
         if (is_data) begin
            res_we_o[addr_i[2:0]] = 1'b1;
         end else if (addr_i == TRACE_ADDR) begin
            trace_inc_o = 1'b1;
         end else if (addr_i == STATUS_ADDR) begin
            status_wr_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tea_io_mailbox.sv
// TEA io mailbox: host block in, CPU computes via io port, result block out.
// Optional key buffer/port enabled by defining TEA_MBOX_KEY_EN.
module tea_io_mailbox
   import tea_pkg::*;
#(
   parameter int                       IO_ADDR_WIDTH = IO_AW,
   parameter logic [IO_ADDR_WIDTH-1:0] STATUS_ADDR   = IO_ADDR_WIDTH'(ADDR_STATUS),
   parameter logic [IO_ADDR_WIDTH-1:0] TRACE_ADDR    = IO_ADDR_WIDTH'(ADDR_TRACE),
   parameter logic [IO_ADDR_WIDTH-1:0] KEY_BASE      = IO_ADDR_WIDTH'(ADDR_KEY_BASE)
) (
   input  logic               clk,
   input  logic               rst,
   tea_io_mailbox_if.slave    bus,
`ifdef TEA_MBOX_KEY_EN
   input  logic [127:0]       key,
`endif
   output state_e             dbg_state_o
);

   state_e      state_q, state_d;
   logic [63:0] in_buf_q, in_buf_d;
   logic [63:0] res_buf_q, res_buf_d;
   logic [63:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  round_cnt_q, round_cnt_d;
   logic [7:0]  res_we;
   logic        trace_inc;
   logic        status_wr;
`ifdef TEA_MBOX_KEY_EN
   logic [127:0] key_buf_q, key_buf_d;
`endif

   tea_io_regmap #(
      .IO_ADDR_WIDTH (IO_ADDR_WIDTH),
      .STATUS_ADDR   (STATUS_ADDR),
      .TRACE_ADDR    (TRACE_ADDR),
      .KEY_BASE      (KEY_BASE)
   ) u_regmap (
      .addr_i      (bus.io_addr),
      .wr_i        (bus.io_wr),
      .state_i     (state_q),
      .out_valid_i (out_valid_q),
      .in_buf_i    (in_buf_q),
      .round_cnt_i (round_cnt_q),
`ifdef TEA_MBOX_KEY_EN
      .key_buf_i   (key_buf_q),
`endif
      .rddata_o    (bus.io_rddata),
      .res_we_o    (res_we),
      .trace_inc_o (trace_inc),
      .status_wr_o (status_wr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         in_buf_q    <= '0;
         res_buf_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         round_cnt_q <= '0;
`ifdef TEA_MBOX_KEY_EN
         key_buf_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         in_buf_q    <= in_buf_d;
         res_buf_q   <= res_buf_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         round_cnt_q <= round_cnt_d;
`ifdef TEA_MBOX_KEY_EN
         key_buf_q   <= key_buf_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      in_buf_d    = in_buf_q;
      res_buf_d   = res_buf_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      round_cnt_d = round_cnt_q;
`ifdef TEA_MBOX_KEY_EN
      key_buf_d   = key_buf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               in_buf_d    = bus.in_data;
               res_buf_d   = '0;
               round_cnt_d = '0;
`ifdef TEA_MBOX_KEY_EN
               key_buf_d   = key;
`endif
               state_d     = ST_PEND;
            end
         end
         ST_PEND: begin
            for (int i = 0; i < DATA_BYTES; i++) begin
               if (res_we[i]) res_buf_d[8*i +: 8] = bus.io_wrdata;
            end
            if (trace_inc) round_cnt_d = round_cnt_q + 8'd1;
            // Only a write with bit0 set signals completion; bit0=0 is a no-op
            if (status_wr && bus.io_wrdata[0]) begin
               out_data_d  = res_buf_q;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.round_cnt = round_cnt_q;
   assign dbg_state_o   = state_q;

endmodule
